// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender with a 2-entry output buffer.
// Extension is done combinationally at acceptance. The result, tag and
// illegal-op flag are then queued in a small FIFO, so producer and consumer
// are decoupled. in_ready depends on registered state only.
module ext_pipe #(
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [2:0]          in_op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam logic [2:0] OpZero      = 3'b000;
    localparam logic [2:0] OpSigned    = 3'b001;
    localparam logic [2:0] OpHighPos   = 3'b010;
    localparam logic [2:0] OpSignedSl2 = 3'b011;
    localparam logic [2:0] OpZeroSl2   = 3'b100;

    localparam logic [ERRCNT_W-1:0] ErrCntMax = '1;

    // Extension datapath
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    assign zext = {{(DATA_W - IMM_W){1'b0}}, in_imm};
    assign sext = {{(DATA_W - IMM_W){in_imm[IMM_W-1]}}, in_imm};

    // Decode the mode; illegal codes give zero data and raise the error flag.
    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_op)
            OpZero:      ext_data = zext;
            OpSigned:    ext_data = sext;
            OpHighPos:   ext_data = {in_imm, {(DATA_W - IMM_W){1'b0}}};
            OpSignedSl2: ext_data = {sext[DATA_W-3:0], 2'b00};
            OpZeroSl2:   ext_data = {zext[DATA_W-3:0], 2'b00};
            default:     ext_err  = 1'b1;
        endcase
    end

    // Buffer state: entry 0 is always the head, entry 1 sits behind it.
    logic [1:0]          count_q, count_d;
    logic [DATA_W-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic [TAG_W-1:0]    tag0_q, tag0_d, tag1_q, tag1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic push;
    logic pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data = data0_q;
    assign out_tag  = tag0_q;
    assign out_err  = err0_q;
    assign err_cnt  = err_cnt_q;

    // Occupancy update
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Entry steering: pop advances entry 1 to the head; a push lands in the
    // first free slot after any pop this cycle, which keeps acceptance order.
    always_comb begin
        data0_d = data0_q;
        tag0_d  = tag0_q;
        err0_d  = err0_q;
        data1_d = data1_q;
        tag1_d  = tag1_q;
        err1_d  = err1_q;
        if (pop && (count_q == 2'd2)) begin
            data0_d = data1_q;
            tag0_d  = tag1_q;
            err0_d  = err1_q;
        end
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                data0_d = ext_data;
                tag0_d  = in_tag;
                err0_d  = ext_err;
            end else begin
                data1_d = ext_data;
                tag1_d  = in_tag;
                err1_d  = ext_err;
            end
        end
    end

    // Saturating count of accepted illegal-op beats
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && ext_err && (err_cnt_q != ErrCntMax)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    // State registers; reset clears payload so outputs read zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 2'd0;
            data0_q   <= '0;
            tag0_q    <= '0;
            err0_q    <= 1'b0;
            data1_q   <= '0;
            tag1_q    <= '0;
            err1_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            data0_q   <= data0_d;
            tag0_q    <= tag0_d;
            err0_q    <= err0_d;
            data1_q   <= data1_d;
            tag1_q    <= tag1_d;
            err1_q    <= err1_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: the driver queues expected beats on
// acceptance, and a monitor pops and compares on every output handshake.
module tb_ext_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_imm;
    logic [2:0]  s_in_op;
    logic [3:0]  s_in_tag;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_data;
    logic [3:0]  s_out_tag;
    logic        s_out_err;
    logic [7:0]  s_err_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ext_pipe u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    ext_pipe #(
        .IMM_W    (8),
        .DATA_W   (16),
        .TAG_W    (4),
        .ERRCNT_W (8)
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_imm    (s_in_imm),
        .in_op     (s_in_op),
        .in_tag    (s_in_tag),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_tag   (s_out_tag),
        .out_err   (s_out_err),
        .err_cnt   (s_err_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference extension for the default 16->32 configuration
    function automatic exp_t model(input logic [15:0] imm, input logic [2:0] op,
                                   input logic [3:0] tag);
        exp_t e;
        e.tag = tag;
        e.err = 1'b0;
        case (op)
            3'd0:    e.data = 32'(imm);
            3'd1:    e.data = 32'($signed(imm));
            3'd2:    e.data = {imm, 16'h0000};
            3'd3:    e.data = 32'($signed(imm)) << 2;
            3'd4:    e.data = 32'(imm) << 2;
            default: begin
                e.data = 32'h0;
                e.err  = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Monitor: compare the head against the scoreboard on every pop
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tag %0h expected none", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                    check("out_err", 64'(out_err), 64'(e.err));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] imm, input logic [2:0] op, input logic [3:0] tag,
                        input exp_t e, input bit queue_it);
        bit acc;
        in_valid = 1'b1;
        in_imm   = imm;
        in_op    = op;
        in_tag   = tag;
        acc      = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && queue_it) exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept tag %0h", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic small_beat(input logic [7:0] imm, input logic [2:0] op,
                              input logic [15:0] exp_data, input string name);
        s_in_valid = 1'b1;
        s_in_imm   = imm;
        s_in_op    = op;
        @(negedge clk);
        check("small_in_ready", 64'(s_in_ready), 64'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check("small_out_valid", 64'(s_out_valid), 64'd1);
        check(name, 64'(s_out_data), 64'(exp_data));
    endtask

    initial begin
        exp_t e;
        int   k;
        bit   acc;
        bit   stream_done;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_imm      = '0;
        in_op       = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_imm    = '0;
        s_in_op     = '0;
        s_in_tag    = '0;
        s_out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Modes with hand-computed results; each visible one cycle after accept
        send(16'h8001, 3'd0, 4'h1, '{32'h0000_8001, 4'h1, 1'b0}, 1'b1);
        check("lat_valid_zero", 64'(out_valid), 64'd1);
        check("lat_tag_zero", 64'(out_tag), 64'h1);
        send(16'h8001, 3'd1, 4'h2, '{32'hFFFF_8001, 4'h2, 1'b0}, 1'b1);
        check("lat_tag_signed", 64'(out_tag), 64'h2);
        send(16'h8001, 3'd2, 4'h3, '{32'h8001_0000, 4'h3, 1'b0}, 1'b1);
        check("lat_tag_highpos", 64'(out_tag), 64'h3);
        send(16'h8001, 3'd3, 4'h4, '{32'hFFFE_0004, 4'h4, 1'b0}, 1'b1);
        check("lat_tag_ssl2", 64'(out_tag), 64'h4);
        send(16'h8001, 3'd4, 4'h5, '{32'h0002_0004, 4'h5, 1'b0}, 1'b1);
        check("lat_tag_zsl2", 64'(out_tag), 64'h5);
        wait_drain();

        // Illegal op then saturation of the error counter
        send(16'h1234, 3'b110, 4'h5, '{32'h0, 4'h5, 1'b1}, 1'b1);
        check("illegal_err_cnt", 64'(err_cnt), 64'd1);
        for (int i = 0; i < 300; i++) begin
            send(16'(i), 3'(5 + (i % 3)), 4'(i), '{32'h0, 4'(i), 1'b1}, 1'b1);
        end
        wait_drain();
        check("err_cnt_saturated", 64'(err_cnt), 64'hFF);

        // Backpressure: two beats fit, third is held
        out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            in_valid = 1'b1;
            in_imm   = 16'(16'h0011 * t);
            in_op    = 3'd1;
            in_tag   = 4'(t);
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), (t < 3) ? 64'd1 : 64'd0);
            if (in_ready) exp_q.push_back(model(16'(16'h0011 * t), 3'd1, 4'(t)));
            @(posedge clk);
            #1;
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_tag", 64'(out_tag), 64'h1);
            check("stall_data", 64'(out_data), 64'h0000_0011);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        acc = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back(model(16'h0033, 3'd1, 4'h3));
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        check("bp_ready_return_cycle", 64'(k), 64'd1);
        wait_drain();

        // Simultaneous push and pop at count 1
        out_ready = 1'b0;
        send(16'h0006, 3'd0, 4'h6, model(16'h0006, 3'd0, 4'h6), 1'b1);
        out_ready = 1'b1;
        send(16'h0007, 3'd0, 4'h7, model(16'h0007, 3'd0, 4'h7), 1'b1);
        check("pp_out_valid", 64'(out_valid), 64'd1);
        check("pp_in_ready", 64'(in_ready), 64'd1);
        check("pp_head_tag", 64'(out_tag), 64'h7);
        wait_drain();

        // Random streaming with toggling out_ready
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [15:0] r_imm;
                    logic [2:0]  r_op;
                    logic [3:0]  r_tag;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    r_imm = 16'($urandom);
                    r_op  = 3'($urandom_range(0, 7));
                    r_tag = 4'(i);
                    send(r_imm, r_op, r_tag, model(r_imm, r_op, r_tag), 1'b1);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset with a full buffer
        out_ready = 1'b0;
        send(16'h00B0, 3'd0, 4'hB, model(16'h00B0, 3'd0, 4'hB), 1'b0);
        send(16'h00C0, 3'd1, 4'hC, model(16'h00C0, 3'd1, 4'hC), 1'b0);
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_err_cnt", 64'(err_cnt), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(16'h000A, 3'd2, 4'hA, model(16'h000A, 3'd2, 4'hA), 1'b1);
        check("post_rst_tag", 64'(out_tag), 64'hA);
        wait_drain();

        // Narrow configuration
        small_beat(8'hF0, 3'd1, 16'hFFF0, "small_signed");
        small_beat(8'hF0, 3'd2, 16'hF000, "small_highpos");
        small_beat(8'hF0, 3'd3, 16'hFFC0, "small_signed_sl2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
